// File: rtl/hydra_pkg.sv
// hydra_pkg: shared packet field layout and router state encoding
package hydra_pkg;
  typedef enum logic [1:0] {DATA0, DATA1, CFG_WR, CFG_RD} pkt_type_t;
  typedef enum logic [1:0] {IDLE, ROUTE, SEND} state_t;
  localparam int TYPE_LSB = 0;
  localparam int ID_LSB = 2;
  localparam int FIFO_FLAG_LSB = 60;
endpackage

// File: rtl/hydra_router_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts after the last accepted grant
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 accept,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] win
);
  localparam int W = $clog2(N);
  logic [W-1:0] ptr;
  logic [N-1:0] rot;
  logic [W:0] sum;
  always_comb begin
    rot = N'({req, req} >> ptr);
    sum = '0;
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (W+1)'(i);
        win = sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : W'(sum);
      end
    end
    grant = |req ? N'(1) << win : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (accept && |req) ptr <= win == W'(N - 1) ? '0 : win + W'(1);
  end
endmodule

// File: rtl/hydra_router.sv
// hydra_router: N-port packet router with round-robin arbitration, watchdog and idle powerdown
module hydra_router
  import hydra_pkg::*;
#(
  parameter int         NUM_PORTS    = 4,
  parameter int         PW           = 63,
  parameter logic [7:0] BROADCAST_ID = 8'hFF,
  parameter int         TIMEOUT      = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PORTS*PW-1:0] rx_data,
  input  logic [NUM_PORTS-1:0]    rx_empty,
  output logic [NUM_PORTS-1:0]    uld_rx,
  output logic [PW-1:0]           tx_data,
  output logic [NUM_PORTS-1:0]    ld_tx,
  input  logic [NUM_PORTS-1:0]    tx_busy,
  output logic [NUM_PORTS-1:0]    tx_powerdown,
  input  logic [NUM_PORTS-1:0]    en_upstream,
  input  logic [NUM_PORTS-1:0]    en_downstream,
  input  logic [NUM_PORTS-1:0]    en_rx,
  input  logic [PW-1:0]           loc_in_data,
  input  logic                    loc_in_valid,
  output logic                    loc_in_ready,
  output logic [PW-1:0]           loc_out_data,
  output logic                    loc_out_valid,
  input  logic                    loc_out_ready,
  input  logic [7:0]              chip_id,
  input  logic                    fifo_full,
  input  logic                    fifo_half,
  input  logic                    pd_enable,
  input  logic [2:0]              pd_cycles,
  output logic [7:0]              drop_count,
  output logic                    busy
);
  localparam int N = NUM_PORTS + 1;
  localparam int SW = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT + 1);
  state_t state;
  pkt_type_t ptype;
  logic [PW-1:0] pkt;
  logic [PW-1:0] cand [N];
  logic [SW-1:0] src, win;
  logic [N-1:0] req, grant;
  logic [NUM_PORTS-1:0] tgt, route_mask, self_bit, pd;
  logic [7:0] idle_cnt [NUM_PORTS];
  logic [7:0] pd_thr, id;
  logic [WDW-1:0] wd;
  logic [2:0] wake;
  logic [1:0] fifo_q;
  logic take, local_src, cfg, route_loc, stamp, loc_pend, tx_pend, fire, tmo, done;
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) cand[i] = rx_data[i*PW +: PW];
    cand[NUM_PORTS] = loc_in_data;
  end
  assign req = {loc_in_valid, en_rx & ~rx_empty};
  assign take = state == IDLE && !reset && |req;
  rr_arbiter #(.N(N)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .accept(take),
    .grant(grant),
    .win(win)
  );
  assign uld_rx = take ? grant[NUM_PORTS-1:0] : '0;
  assign loc_in_ready = take & grant[NUM_PORTS];
  assign ptype = pkt_type_t'(pkt[TYPE_LSB +: 2]);
  assign id = pkt[ID_LSB +: 8];
  assign local_src = src == SW'(NUM_PORTS);
  assign cfg = ptype == CFG_WR || ptype == CFG_RD;
  always_comb begin
    self_bit = local_src ? '0 : NUM_PORTS'(1) << src;
    route_loc = !local_src && cfg && (id == chip_id || id == BROADCAST_ID);
    route_mask = local_src ? en_upstream :
                 cfg ? (id == chip_id ? '0 : en_downstream & ~self_bit) :
                 en_upstream & ~self_bit;
    stamp = local_src && ptype == CFG_RD && id == chip_id;
  end
  assign fire = state == SEND && tx_pend && wake == 3'd0 && (tx_busy & tgt) == '0;
  assign tmo = state == SEND && tx_pend && !fire && wd == WDW'(TIMEOUT - 1);
  assign done = (!loc_pend || loc_out_ready) && (!tx_pend || fire || tmo);
  assign ld_tx = fire ? tgt : '0;
  assign loc_out_valid = state == SEND && loc_pend;
  assign loc_out_data = pkt;
  assign tx_data = pkt;
  assign busy = state != IDLE;
  assign tx_powerdown = pd;
  assign pd_thr = {1'b0, pd_cycles, 4'b0} + 8'd16;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pkt <= '0;
      src <= '0;
      tgt <= '0;
      loc_pend <= 1'b0;
      tx_pend <= 1'b0;
      wake <= '0;
      wd <= '0;
      drop_count <= '0;
      fifo_q <= '0;
    end else begin
      fifo_q <= {fifo_full, fifo_half};
      if (take) begin
        pkt <= cand[win];
        src <= win;
        state <= ROUTE;
      end else if (state == ROUTE) begin
        tgt <= route_mask;
        loc_pend <= route_loc;
        tx_pend <= |route_mask;
        wd <= '0;
        wake <= |(route_mask & pd) ? 3'd4 : 3'd0;
        if (stamp) pkt[FIFO_FLAG_LSB +: 2] <= fifo_q;
        state <= route_mask == '0 && !route_loc ? IDLE : SEND;
      end else if (state == SEND) begin
        if (wake != 3'd0) wake <= wake - 3'd1;
        if (loc_out_ready) loc_pend <= 1'b0;
        if (fire || tmo) tx_pend <= 1'b0;
        else if (tx_pend) wd <= wd + WDW'(1);
        if (tmo && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        if (done) state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (reset) begin
        idle_cnt[i] <= '0;
        pd[i] <= 1'b0;
      end else begin
        if (ld_tx[i] || tx_busy[i] || (state == ROUTE && route_mask[i])) idle_cnt[i] <= '0;
        else if (idle_cnt[i] != 8'hFF) idle_cnt[i] <= idle_cnt[i] + 8'd1;
        if (!pd_enable || (state == ROUTE && route_mask[i])) pd[i] <= 1'b0;
        else if (idle_cnt[i] >= pd_thr) pd[i] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hydra_router.sv
// tb_hydra_router: directed and randomized checks of hydra_router against a rule-level model
module tb_hydra_router;
  localparam int NP = 4;
  localparam int PW = 63;
  localparam int TIMEOUT = 1023;
  logic clk = 1'b0;
  logic reset;
  logic [NP*PW-1:0] rx_data;
  logic [NP-1:0] rx_empty, uld_rx, ld_tx, tx_busy, tx_powerdown, en_upstream, en_downstream, en_rx;
  logic [PW-1:0] tx_data, loc_in_data, loc_out_data;
  logic loc_in_valid, loc_in_ready, loc_out_valid, loc_out_ready;
  logic [7:0] chip_id, drop_count;
  logic fifo_full, fifo_half, pd_enable, busy;
  logic [2:0] pd_cycles;
  int checks = 0;
  int errors = 0;
  int model_next = 0;
  int exp_drops = 0;
  logic [NP-1:0] last_ldm;
  logic [PW-1:0] last_ldd, last_locd;
  int last_locn;
  always #5 clk = ~clk;
  hydra_router #(.NUM_PORTS(NP), .PW(PW), .BROADCAST_ID(8'hFF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .uld_rx(uld_rx),
    .tx_data(tx_data), .ld_tx(ld_tx), .tx_busy(tx_busy), .tx_powerdown(tx_powerdown),
    .en_upstream(en_upstream), .en_downstream(en_downstream), .en_rx(en_rx),
    .loc_in_data(loc_in_data), .loc_in_valid(loc_in_valid), .loc_in_ready(loc_in_ready),
    .loc_out_data(loc_out_data), .loc_out_valid(loc_out_valid), .loc_out_ready(loc_out_ready),
    .chip_id(chip_id), .fifo_full(fifo_full), .fifo_half(fifo_half), .pd_enable(pd_enable),
    .pd_cycles(pd_cycles), .drop_count(drop_count), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input int s, input logic [PW-1:0] p, output logic [NP-1:0] m,
                                output bit loc, output logic [PW-1:0] q);
    bit is_cfg = p[1];
    q = p;
    loc = 0;
    if (s == NP) begin
      m = en_upstream;
      if (p[1:0] == 2'b11 && p[9:2] == chip_id) begin
        q[61] = fifo_full;
        q[60] = fifo_half;
      end
    end else begin
      m = is_cfg ? en_downstream : en_upstream;
      m[s] = 1'b0;
      if (is_cfg && p[9:2] == chip_id) begin
        loc = 1;
        m = '0;
      end else if (is_cfg && p[9:2] == 8'hFF) loc = 1;
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int s, input logic [PW-1:0] p, input bit stuck, input bit wake);
    logic [NP-1:0] em;
    bit el;
    logic [PW-1:0] eq;
    int c, ldn, ldc, exp_end;
    model(s, p, em, el, eq);
    if (s == NP) begin
      loc_in_data = p;
      loc_in_valid = 1'b1;
    end else begin
      rx_data[s*PW +: PW] = p;
      rx_empty[s] = 1'b0;
    end
    #1;
    chk("grant", {loc_in_ready, uld_rx}, 5'b1 << s);
    model_next = (s + 1) % (NP + 1);
    tick();
    loc_in_valid = 1'b0;
    rx_empty = '1;
    c = 1;
    ldn = 0;
    ldc = 0;
    last_locn = 0;
    last_ldm = '0;
    do begin
      tick();
      c++;
      if (ld_tx != '0) begin
        ldn++;
        last_ldm |= ld_tx;
        last_ldd = tx_data;
        ldc = c;
      end
      if (loc_out_valid && loc_out_ready) begin
        last_locn++;
        last_locd = loc_out_data;
      end
    end while (busy && c < 3000);
    if (stuck && exp_drops < 255) exp_drops++;
    exp_end = (em == '0 && !el) ? 2 : stuck ? 2 + TIMEOUT : 3 + 4 * int'(wake);
    chk("end_cycle", 64'(c), 64'(exp_end));
    chk("ld_mask", last_ldm, stuck ? '0 : em);
    chk("ld_count", 64'(ldn), (em != '0 && !stuck) ? 64'd1 : 64'd0);
    if (ldn != 0) begin
      chk("ld_cycle", 64'(ldc), 64'(2 + 4 * int'(wake)));
      chk("ld_data", last_ldd, eq);
    end
    chk("loc_count", 64'(last_locn), 64'(el));
    if (last_locn != 0) chk("loc_data", last_locd, eq);
    chk("drops", drop_count, 64'(exp_drops));
  endtask
  initial begin
    logic [PW-1:0] p, locp;
    logic [PW-1:0] rxp [2];
    logic [PW-1:0] expq [$];
    logic [4:0] gv;
    int got, cyc, e, s;
    reset = 1'b1;
    rx_data = '0;
    rx_empty = 4'b1100;
    en_rx = '1;
    tx_busy = '0;
    en_upstream = '0;
    en_downstream = '0;
    loc_in_data = '0;
    loc_in_valid = 1'b1;
    loc_out_ready = 1'b1;
    chip_id = 8'h12;
    fifo_full = 1'b0;
    fifo_half = 1'b0;
    pd_enable = 1'b0;
    pd_cycles = 3'd0;
    repeat (3) tick();
    chk("rst_uld", uld_rx, 0);
    chk("rst_lrdy", loc_in_ready, 0);
    chk("rst_ld", ld_tx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_pd", tx_powerdown, 0);
    chk("rst_lval", loc_out_valid, 0);
    rx_empty = '1;
    loc_in_valid = 1'b0;
    reset = 1'b0;
    tick();
    en_upstream = 4'b1000;
    rxp[0] = PW'({$urandom(), $urandom()}) & ~PW'(3);
    rxp[1] = (PW'({$urandom(), $urandom()}) & ~PW'(3)) | PW'(1);
    locp = (PW'({$urandom(), $urandom()}) & ~PW'(3)) | PW'(1);
    rx_data[0 +: PW] = rxp[0];
    rx_data[PW +: PW] = rxp[1];
    loc_in_data = locp;
    rx_empty = 4'b1100;
    loc_in_valid = 1'b1;
    #1;
    got = 0;
    cyc = 0;
    while (got < 12 && cyc < 300) begin
      gv = {loc_in_ready, uld_rx};
      if (gv != '0) begin
        e = -1;
        for (int k = 0; k <= NP; k++) begin
          s = (model_next + k) % (NP + 1);
          if (e < 0 && (s == 0 || s == 1 || s == NP)) e = s;
        end
        chk("arb_grant", gv, 5'b1 << e);
        expq.push_back(e == NP ? locp : rxp[e]);
        model_next = (e + 1) % (NP + 1);
        got++;
      end
      if (ld_tx != '0) begin
        chk("arb_ld", ld_tx, 4'b1000);
        chk("arb_data", tx_data, expq.size() != 0 ? expq[0] : 'x);
        if (expq.size() != 0) void'(expq.pop_front());
      end
      tick();
      cyc++;
    end
    rx_empty = '1;
    loc_in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      if (ld_tx != '0) begin
        chk("arb_data", tx_data, expq.size() != 0 ? expq[0] : 'x);
        if (expq.size() != 0) void'(expq.pop_front());
      end
      tick();
      cyc++;
    end
    chk("arb_grants", 64'(got), 64'd12);
    chk("arb_drain", 64'(expq.size()), 64'd0);
    en_upstream = 4'b0001;
    p = PW'({$urandom(), $urandom()});
    p[1:0] = 2'b01;
    send(NP, p, 0, 0);
    chk("t1_ld", last_ldm, 4'b0001);
    chk("t1_data", last_ldd, p);
    p = PW'({$urandom(), $urandom()});
    p[1:0] = 2'b10;
    p[9:2] = 8'h12;
    en_downstream = 4'b1111;
    send(2, p, 0, 0);
    chk("t2_ld", last_ldm, 4'b0000);
    chk("t2_loc", last_locd, p);
    p[9:2] = 8'hFF;
    en_downstream = 4'b0111;
    send(0, p, 0, 0);
    chk("t3_ld", last_ldm, 4'b0110);
    chk("t3_loc", 64'(last_locn), 64'd1);
    for (int n = 0; n < 30; n++) begin
      en_upstream = 4'($urandom());
      en_downstream = 4'($urandom());
      chip_id = 8'($urandom_range(0, 254));
      fifo_full = 1'($urandom());
      fifo_half = 1'($urandom());
      p = PW'({$urandom(), $urandom()});
      e = $urandom_range(0, 2);
      p[9:2] = e == 0 ? chip_id : e == 1 ? 8'hFF : 8'($urandom());
      send($urandom_range(0, NP), p, 0, 0);
    end
    chip_id = 8'h12;
    en_upstream = 4'b0010;
    tx_busy = 4'b0010;
    p = PW'({$urandom(), $urandom()});
    p[1:0] = 2'b00;
    send(NP, p, 1, 0);
    chk("to_drop", drop_count, 8'd1);
    tx_busy = '0;
    fifo_full = 1'b0;
    fifo_half = 1'b1;
    en_upstream = 4'b0100;
    p = PW'({$urandom(), $urandom()});
    p[1:0] = 2'b11;
    p[9:2] = 8'h12;
    p[61:60] = 2'b10;
    send(NP, p, 0, 0);
    chk("stamp", last_ldd[61:60], 2'b01);
    pd_enable = 1'b1;
    pd_cycles = 3'd0;
    repeat (40) tick();
    chk("pd_all", tx_powerdown, 4'b1111);
    en_upstream = 4'b0001;
    p[1:0] = 2'b01;
    send(NP, p, 0, 1);
    chk("pd_wake", tx_powerdown, 4'b1110);
    repeat (12) tick();
    chk("pd_early", tx_powerdown, 4'b1110);
    repeat (10) tick();
    chk("pd_again", tx_powerdown, 4'b1111);
    pd_enable = 1'b0;
    tick();
    loc_in_data = p;
    loc_in_valid = 1'b1;
    tick();
    loc_in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("abort_ld", ld_tx, 0);
      chk("abort_busy", busy, 0);
    end
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_idle_ld", ld_tx, 0);
    end
    chk("abort_drop", drop_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
